// File: rtl/ram_multi_read_port.sv
// Register-file RAM: one byte-maskable write port, NUM_READ registered read ports,
// byte-accurate write-to-read bypass and a built-in zeroing sequencer.
module ram_multi_read_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 16,
    parameter int NUM_READ   = 4
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iClear,
    input  logic                           iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]          iWriteAddress,
    input  logic [DATA_WIDTH/8-1:0]        iWriteByteEnable,
    input  logic [DATA_WIDTH-1:0]          iDataIn,
    input  logic [NUM_READ-1:0]            iReadEnable,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
    output logic [NUM_READ-1:0]            oDataValid,
    output logic                           oReady
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT    = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [CW-1:0]       LAST_IDX = CW'(MEM_SIZE - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         counter, counter_next;
    logic [DATA_WIDTH-1:0] ram [MEM_SIZE];

    logic                  run_active;
    logic                  write_ok;
    logic [CW-1:0]         write_idx;
    logic [DATA_WIDTH-1:0] merged;
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_word [NUM_READ];

    // Extra leading bit keeps the compare correct when MEM_SIZE == 2**ADDR_WIDTH.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    assign run_active = (state == RUN) && !iClear;
    assign write_ok   = run_active && iWriteEnable && in_range(iWriteAddress);
    assign write_idx  = iWriteAddress[CW-1:0];
    assign oReady     = (state == RUN);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            CLEAR: begin
                if (counter == LAST_IDX) begin
                    state_next   = RUN;
                    counter_next = '0;
                end else begin
                    counter_next = counter + CW'(1);
                end
            end
            RUN: begin
                if (iClear) begin
                    state_next   = CLEAR;
                    counter_next = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        merged = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            merged[8*b +: 8] = iWriteByteEnable[b] ? iDataIn[8*b +: 8] : ram[write_idx][8*b +: 8];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state == CLEAR) begin
                ram[counter] <= '0;
            end else if (write_ok) begin
                ram[write_idx] <= merged;
            end
        end
    end

    // Out-of-range reads return zero even if the same address is being written.
    always_comb begin
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            rd_addr[k] = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_word[k] = '0;
            if (in_range(rd_addr[k])) begin
                if (write_ok && (rd_addr[k] == iWriteAddress)) begin
                    rd_word[k] = merged;
                end else begin
                    rd_word[k] = ram[rd_addr[k][CW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oDataOut   <= '0;
            oDataValid <= '0;
        end else if (run_active) begin
            for (int unsigned k = 0; k < NUM_READ; k++) begin
                oDataValid[k] <= iReadEnable[k];
                if (iReadEnable[k]) begin
                    oDataOut[k*DATA_WIDTH +: DATA_WIDTH] <= rd_word[k];
                end
            end
        end else begin
            oDataValid <= '0;
        end
    end
endmodule

// File: doc/ram_multi_read_port.md
Name: ram_multi_read_port

Overview:
- Parametrised register-file RAM: one byte-maskable write port and NUM_READ independent registered read ports.
- Write-to-read bypass is byte-accurate: a read of the address being written returns the merged word.
- A built-in clear sequencer zeroes every location after reset or on request; oReady flags when the array is usable.
- Serves as the shared operand/register store feeding the datapath's parallel operand fetch.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- MEM_SIZE, 16, number of words (addresses 0..MEM_SIZE-1); must be ≤ 2^ADDR_WIDTH and ≥ 2.
- NUM_READ, 4, number of read ports; must be ≥ 1.

Ports:
- Clock, input, 1, single clock; all state changes on the rising edge.
- Reset, input, 1, synchronous, active-high.
- iClear, input, 1, requests a full zeroing pass; honoured only in RUN.
- iWriteEnable, input, 1, write strobe.
- iWriteAddress, input, ADDR_WIDTH, write address.
- iWriteByteEnable, input, DATA_WIDTH/8, per-byte write mask; bit b covers data bits [8b+7:8b].
- iDataIn, input, DATA_WIDTH, write data.
- iReadEnable, input, NUM_READ, per-port read strobe.
- iReadAddress, input, NUM_READ*ADDR_WIDTH, packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- oDataOut, output, NUM_READ*DATA_WIDTH, packed registered read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- oDataValid, output, NUM_READ, bit k is high for one cycle when port k's data was updated by a read.
- oReady, output, 1, high when the array is in RUN.

Behaviour:
- Clock, reset and priority
  - One clock: Clock. Reset is synchronous and active-high.
  - Reset sampled high overrides everything, including mid-clear and a pending write.
  - Reset values: state=CLEAR, clear counter=0, oReady=0, oDataOut=0, oDataValid=0.
- State machine: two states, CLEAR and RUN.
- CLEAR
  - Each edge writes 0 to Ram[counter] and increments counter.
  - The edge that clears MEM_SIZE-1 moves to RUN, sets oReady←1 and resets counter to 0.
  - oReady therefore rises after exactly MEM_SIZE edges with Reset low.
  - iWriteEnable, iReadEnable and iClear are ignored; oDataValid=0; oDataOut holds its value.
- RUN, iClear high
  - Next edge enters CLEAR with counter=0 and oReady←0.
  - A write presented on that same edge is dropped; reads on that edge are not performed (oDataValid←0).
- RUN, write
  - Condition: iWriteEnable=1 and iWriteAddress<MEM_SIZE.
  - Ram[addr] byte b ← iDataIn byte b where iWriteByteEnable[b]=1; other bytes are unchanged.
  - Out-of-range write addresses are ignored silently.
- RUN, read port k
  - If iReadEnable[k]=1, on the edge: oDataValid[k]←1 and the oDataOut slice ← read word. Latency is 1 cycle.
  - If iReadEnable[k]=0: oDataValid[k]←0 and the slice holds.
  - Read word, in order of precedence:
    - address ≥ MEM_SIZE → 0;
    - else if a write is accepted on the same edge to the same address → per byte, iDataIn where the byte enable is set, else old Ram content (bypass, new data);
    - else Ram[address].
- Ports are fully independent: any number of ports may read the same address on the same edge.
- Simultaneous Reset and iClear: Reset wins; the result is the same clear from address 0.

Test Plan:
- Reset high 2 cycles, then low; MEM_SIZE=16 → oReady=0 for 16 edges and 1 from edge 16. All 4 ports then read addresses 0,5,10,15 → data 0, valid=4'b1111 one cycle later.
- Write 0xBEEF to addr 3 with byte enable 2'b11; next cycle port 2 reads addr 3 → oDataOut[47:32]=0xBEEF, oDataValid[2]=1.
- Addr 3 holds 0xBEEF. Same edge: write 0x1234 to addr 3 with byte enable 2'b01, port 0 and port 1 both read addr 3 → both return 0xBE34; Ram[3]=0xBE34 afterwards.
- iClear pulse in RUN together with a write of 0xAAAA to addr 7 → oReady=0 for 16 edges, then port 0 reads addr 7 → 0x0000. An iClear pulse during the clear does not extend it.
- Reset asserted midway through a clear (counter=9) → counter restarts at 0; oReady rises 16 edges after Reset falls.
- Write to addr 20 (≥MEM_SIZE), then read addr 20 → data 0, valid 1, no location altered. Ports with iReadEnable=0 hold their data and show valid 0.
